fsm_prob_b: RTL and testbench



---
 rtl/fsm_prob_b_pkg.sv | 19 +
 rtl/fsm_prob_b.sv | 70 +++++++
 tb/tb_fsm_prob_b.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fsm_prob_b_pkg.sv
// Shared types for the fsm_prob_b control block: state encoding and output decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fsm_prob_b_pkg;

  // Every 2-bit code is a legal state, so the FSM needs no recovery path.
  typedef enum logic [1:0] {
    A = 2'b00,
    B = 2'b01,
    C = 2'b10,
    D = 2'b11
  } state_t;

  // Moore output decode: {x,y} is the state code itself.
  function automatic logic [1:0] out_of(input state_t s);
    return logic'(s[1]) ? {1'b1, s[0]} : {1'b0, s[0]};
  endfunction

endpackage

// File: rtl/fsm_prob_b.sv
// Four-state Moore FSM on inputs i/j; outputs {x,y} encode the current state.
// Latency: one clk edge from i/j to x/y; sync active-low reset forces state A (xy=00).
// Backpressure: none, accepts i/j every cycle. Build option FSM_PROB_B_REGOUT_EN
// drives x/y from dedicated flops loaded with the decode of next_state.
module fsm_prob_b
  import fsm_prob_b_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic i,
  input  logic j,
  output logic x,
  output logic y
);

  state_t state;
  state_t next_state;

  // Next-state rules; within each state the first matching condition wins.
  always_comb begin
    next_state = state;
    case (state)
      A: begin
        if (i)      next_state = B;
        else if (j) next_state = C;
        else        next_state = A;
      end
      B: begin
        if (i)      next_state = C;
        else if (j) next_state = A;
        else        next_state = B;
      end
      C: begin
        if (j)      next_state = D;
        else if (i) next_state = A;
        else        next_state = C;
      end
      D: begin
        if (i)      next_state = A;
        else if (j) next_state = D;
        else        next_state = B;
      end
      default: next_state = A;
    endcase
  end

  // State register; reset takes priority over any input combination.
  always_ff @(posedge clk) begin
    if (!rstn) state <= A;
    else       state <= next_state;
  end

`ifdef FSM_PROB_B_REGOUT_EN
  logic [1:0] xy_q;

  // Output flops track the state register exactly, so x/y are glitch-free.
  always_ff @(posedge clk) begin
    if (!rstn) xy_q <= 2'b00;
    else       xy_q <= out_of(next_state);
  end

  assign {x, y} = xy_q;
`else
  // Plain combinational decode of the state register.
  always_comb begin
    {x, y} = out_of(state);
  end
`endif

endmodule

// File: tb/tb_fsm_prob_b.sv
// Scoreboard bench for fsm_prob_b: a driver issues i/j/rstn on the falling edge
// and queues the expected {x,y}; a monitor pops and compares just after each
// rising edge. Expectations come from a transition table of the state machine.
module tb_fsm_prob_b;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i = 1'b0;
  logic j = 1'b0;
  logic x;
  logic y;

  fsm_prob_b dut (
    .clk (clk),
    .rstn(rstn),
    .i   (i),
    .j   (j),
    .x   (x),
    .y   (y)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Expected {x,y} after each edge, plus a label for the step.
  logic [1:0] exp_q[$];
  string      tag_q[$];

  // Reference model: state numbered 0..3 (A..D), table indexed [state][{i,j}].
  int tbl[4][4];
  int mstate = -1;  // unknown until first reset edge

  function automatic void build_table();
    // state A
    tbl[0][0] = 0; tbl[0][1] = 2; tbl[0][2] = 1; tbl[0][3] = 1;
    // state B
    tbl[1][0] = 1; tbl[1][1] = 0; tbl[1][2] = 2; tbl[1][3] = 2;
    // state C
    tbl[2][0] = 2; tbl[2][1] = 3; tbl[2][2] = 0; tbl[2][3] = 3;
    // state D
    tbl[3][0] = 1; tbl[3][1] = 3; tbl[3][2] = 0; tbl[3][3] = 0;
  endfunction

  // Apply one cycle of stimulus and queue the expected output after the edge.
  task automatic step(input logic r, input logic ii, input logic jj, input string tag);
    @(negedge clk);
    rstn = r;
    i    = ii;
    j    = jj;
    if (!r) begin
      mstate = 0;
    end else if (mstate >= 0) begin
      mstate = tbl[mstate][{30'd0, ii, jj}];
    end
    if (mstate >= 0) begin
      exp_q.push_back(2'(mstate));
      tag_q.push_back(tag);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard just after each edge.
  initial begin
    logic [1:0] e;
    string      t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        if ({x, y} !== e) begin
          miscompares++;
          $display("FAIL %s: xy got %b%b expected %b", t, x, y, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    build_table();

    // Reset held two edges with ij=10, then release and move to B.
    step(1'b0, 1'b1, 1'b0, "reset_edge1");
    step(1'b0, 1'b1, 1'b0, "reset_edge2");
    step(1'b1, 1'b1, 1'b0, "release_to_B");

    // Main sequence from A.
    step(1'b0, 1'b0, 1'b0, "main_reset");
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, "main_ij10");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, "main_ij01");
    step(1'b1, 1'b0, 1'b0, "main_ij00_D");
    step(1'b1, 1'b1, 1'b0, "main_ij10_B");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, "main_hold_C");

    // Priority with ij=11 visits A->B->C->D->A.
    step(1'b0, 1'b0, 1'b0, "prio_reset");
    step(1'b1, 1'b1, 1'b1, "prio_A11");
    step(1'b1, 1'b1, 1'b1, "prio_B11");
    step(1'b1, 1'b1, 1'b1, "prio_C11");
    step(1'b1, 1'b1, 1'b1, "prio_D11");

    // Hold behaviour with ij=00 in each state.
    step(1'b0, 1'b0, 1'b0, "hold_reset");
    step(1'b1, 1'b0, 1'b0, "hold_A");
    step(1'b1, 1'b1, 1'b0, "hold_goB");
    step(1'b1, 1'b0, 1'b0, "hold_B");
    step(1'b1, 1'b1, 1'b0, "hold_goC");
    step(1'b1, 1'b0, 1'b0, "hold_C");
    step(1'b1, 1'b0, 1'b1, "hold_goD");
    step(1'b1, 1'b0, 1'b0, "hold_D_to_B");

    // Mid-run reset from D, then resume.
    step(1'b0, 1'b0, 1'b0, "mid_reset0");
    step(1'b1, 1'b0, 1'b1, "mid_goC");
    step(1'b1, 1'b0, 1'b1, "mid_goD");
    step(1'b0, 1'b0, 1'b1, "mid_reset_in_D");
    step(1'b1, 1'b0, 1'b1, "mid_after_release");

    // Randomized stimulus with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic r;
      r = ($urandom_range(0, 15) != 0);
      step(r, 1'($urandom), 1'($urandom), "random");
    end

    // Drain the scoreboard, bounded.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs never checked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
